mul_accum: RTL

//   Downstream stage of the 8x8 unsigned array multiplier. Accepts the 16-bit

---
 rtl/mul_accum_if.sv | 27 ++
 rtl/mul_accum.sv | 88 ++++++++
 2 files changed

// File: rtl/mul_accum_if.sv
// Handshake bundle between the multiplier product stream, the accumulator and its result consumer.
// slave is the accumulator's view; master is the producer/consumer side.
interface mul_accum_if #(
  parameter int PW   = 16,
  parameter int ACCW = 24,
  parameter int CNTW = 9
);
  logic            in_valid;
  logic            in_ready;
  logic [PW-1:0]   in_p;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [ACCW-1:0] out_acc;
  logic [CNTW-1:0] out_cnt;
  logic            out_ovf;

  modport slave (
    input  in_valid, in_p, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_cnt, out_ovf
  );

  modport master (
    output in_valid, in_p, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_cnt, out_ovf
  );
endinterface

// File: rtl/mul_accum.sv
// Accumulates an unsigned product stream and presents sum/beat count/overflow
// when the beat flagged last arrives.
module mul_accum #(
  parameter int PW   = 16,
  parameter int ACCW = 24,
  parameter int CNTW = 9,
  parameter bit SAT  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  mul_accum_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  state_e          state_q;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            out_valid_q;
  logic [ACCW:0]   sum;

  // One extra bit of headroom exposes the carry out of the accumulator.
  always_comb begin
    sum   = {1'b0, acc_q} + {{(ACCW+1-PW){1'b0}}, bus.in_p};
    acc_d = sum[ACCW-1:0];
    ovf_d = ovf_q;
    if (sum[ACCW]) begin
      ovf_d = 1'b1;
      if (SAT) acc_d = '1;
    end
    cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNTW'(1);
  end

  assign bus.in_ready  = rst_n && !clr && (state_q != HOLD);
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = acc_q;
  assign bus.out_cnt   = cnt_q;
  assign bus.out_ovf   = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clr) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          // in_ready is guaranteed high in these states once past reset/clr
          if (bus.in_valid) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (bus.in_last) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
            end else begin
              state_q     <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
